pixel_feeder: RTL and testbench
===============================

# pixel_feeder

Tile-side streaming source for the CPE pixel register chain. On `start` it walks one tile of a feature map held in on-chip SRAM in raster order and pushes one pixel per cycle into the chain. It drives the chain's `pixel_in`, `chain_run` and `sel` inputs and flags each cycle in which the chain holds a complete 3x3 window. It sits between the tile buffer SRAM and the register chain, under the CPE control logic.

## Interface
- `WIDTH`, 16, pixel width.
- `SEL_WIDTH`, 5, chain line-tap select width; maximum tile width is 2**SEL_WIDTH.
- `H_WIDTH`, 8, tile-height field width.
- `ADDR_WIDTH`, 10, SRAM word-address width.
- `clock` in 1, single clock; all logic on posedge.
- `rst_n` in 1, asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1, one-cycle request; sampled only in IDLE.
- `tile_w` in SEL_WIDTH+1, tile width in pixels; legal range 3..2**SEL_WIDTH.
- `tile_h` in H_WIDTH, tile height in rows; legal range 3..2**H_WIDTH-1.
- `base_addr` in ADDR_WIDTH, SRAM address of pixel (0,0).
- `stall` in 1, downstream hold; while high, no new SRAM reads are issued.
- `mem_rd_en` out 1, SRAM read strobe.
- `mem_rd_addr` out ADDR_WIDTH, SRAM read address.
- `mem_rd_data` in WIDTH, SRAM data; valid exactly 1 cycle after `mem_rd_en`.
- `pixel_out` out WIDTH, drives the chain's `pixel_in`; combinational pass-through of `mem_rd_data`.
- `chain_run` out 1, chain advance; high exactly when `pixel_out` carries a valid pixel.
- `sel` out SEL_WIDTH, registered `tile_w-1`; stable for the whole tile.
- `window_valid` out 1, chain holds a full 3x3 window.
- `win_row` out H_WIDTH, window row coordinate.
- `win_col` out SEL_WIDTH, window column coordinate.
- `busy` out 1, high from the cycle after an accepted `start` through DONE.
- `done` out 1, one-cycle pulse at tile completion.
- `err` out 1, one-cycle pulse when `start` is rejected.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, legal `start`: latch `tile_w`, `tile_h`, `base_addr`; load `sel` <= `tile_w-1`; clear counters row=0, col=0; go to RUN.
- IDLE, illegal dimensions: pulse `err` next cycle; remain in IDLE.
- `start` in any state other than IDLE is ignored (no `err`).
- RUN, each cycle with `stall`=0:
  - assert `mem_rd_en` with `mem_rd_addr` = running address.
  - running address starts at `base_addr` and increments by 1 per read, wrapping mod 2**ADDR_WIDTH.
  - col increments; on col==tile_w-1, col wraps to 0 and row increments.
- RUN, after the read of (tile_h-1, tile_w-1): go to DRAIN.
- RUN, `stall`=1: `mem_rd_en`=0; counters and address hold.
- DRAIN: lasts 1 cycle; delivers the final in-flight pixel; then DONE.
- DONE: `done`=1 for 1 cycle; return to IDLE.
- `chain_run` = `mem_rd_en` delayed 1 cycle. A read issued before `stall` rises is still pushed.
- Each read carries a delayed (row, col) tag alongside the data.
- `window_valid` is registered: high in the cycle after a push whose tag has row>=2 and col>=2.
  - `win_row`/`win_col` = that pushed pixel's tag, i.e. the bottom-right pixel of the window.
  - Pushes with col<2 never raise `window_valid`; windows never span a row boundary.
- Reset, mid-operation: return to IDLE immediately.
  - All outputs reset to 0: `mem_rd_en`, `chain_run`, `window_valid`, `busy`, `done`, `err`, `sel`, `win_row`, `win_col`, `mem_rd_addr`.
  - `pixel_out` follows `mem_rd_data`, which is ignored because `chain_run`=0.

## Timing
- `start` sampled at edge T: first `mem_rd_en` at T+1; first `chain_run` at T+2.
- Unstalled tile: `done` at T+1+tile_w*tile_h+1.
- Each stall cycle during RUN adds exactly 1 cycle.
- `window_valid` lags the corresponding `chain_run` by 1 cycle.
- Windows per tile = (tile_h-2)*(tile_w-2).
- `stall` acts in the same cycle it is high (gates `mem_rd_en` combinationally from state and counters).

## Structure
- Shared package `cpe_pkg`:
  - `KERNEL_SIZE`=3.
  - FSM state enum `feeder_state_t`.
  - Packed tile-descriptor struct {w, h, base}, shared with the CPE control logic.
- Sub-module `tile_counter`: row/col/address counters with enable and wrap. Everything else stays in the top.

## Test plan
- 4x3 tile, base 0x010, no stall:
  - 12 reads at addresses 0x010..0x01B.
  - `sel`=3.
  - Exactly 2 `window_valid` pulses, with (win_row,win_col) = (2,2) then (2,3).
  - `done` 14 cycles after `start`.
- Same tile with `stall` high for 3 cycles mid-row: the identical pixel/tag sequence is produced; `done` comes 3 cycles later.
- `tile_w`=2, `tile_h`=5 → `err` pulse; no reads; `busy` stays 0.
- `tile_w`=32, `tile_h`=3, base 0x3F0:
  - Address wraps 0x3FF→0x000.
  - `sel`=31.
  - 30 windows.
- Assert `rst_n` low during RUN: all outputs go to 0 asynchronously. A fresh `start` afterwards runs a complete, correct tile.
- `start` pulsed while busy: ignored; no `err`; the current tile completes unaffected.

Source files
------------

// File: rtl/cpe_pkg.sv
// cpe_pkg: shared CPE types, kernel geometry and tile-dimension check
package cpe_pkg;

    localparam int KERNEL_SIZE = 3;

    localparam int TILE_W_BITS    = 6;
    localparam int TILE_H_BITS    = 8;
    localparam int TILE_ADDR_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } feeder_state_t;

    typedef struct packed {
        logic [TILE_W_BITS-1:0]    w;
        logic [TILE_H_BITS-1:0]    h;
        logic [TILE_ADDR_BITS-1:0] base;
    } tile_desc_t;

    // A tile must hold at least one full kernel window and fit the chain taps.
    function automatic logic tile_dims_ok(input int w, input int h, input int w_max, input int h_max);
        return w >= KERNEL_SIZE && w <= w_max && h >= KERNEL_SIZE && h <= h_max;
    endfunction

endpackage

// File: rtl/pixel_feeder_tile_counter.sv
// tile_counter: raster row/col walk plus wrapping SRAM read address
module tile_counter
    import cpe_pkg::*;
#(
    parameter int SEL_WIDTH  = 5,
    parameter int H_WIDTH    = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [SEL_WIDTH-1:0]  col_last,
    output logic [H_WIDTH-1:0]    row,
    output logic [SEL_WIDTH-1:0]  col,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic col_wrap;

    assign col_wrap = col == col_last;

    // Load the tile origin, then step one pixel per enabled cycle in raster order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (load) begin
            row  <= '0;
            col  <= '0;
            addr <= base;
        end else if (en) begin
            addr <= addr + 1'b1;
            col  <= col_wrap ? '0 : col + 1'b1;
            row  <= col_wrap ? row + 1'b1 : row;
        end
    end

endmodule

// File: rtl/pixel_feeder.sv
// pixel_feeder: streams one SRAM tile in raster order into the CPE pixel chain
module pixel_feeder
    import cpe_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SEL_WIDTH  = 5,
    parameter int H_WIDTH    = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEL_WIDTH:0]    tile_w,
    input  logic [H_WIDTH-1:0]    tile_h,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]      mem_rd_data,
    output logic [WIDTH-1:0]      pixel_out,
    output logic                  chain_run,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  window_valid,
    output logic [H_WIDTH-1:0]    win_row,
    output logic [SEL_WIDTH-1:0]  win_col,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [H_WIDTH-1:0]   EDGE_ROW = H_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [SEL_WIDTH-1:0] EDGE_COL = SEL_WIDTH'(KERNEL_SIZE - 1);

    feeder_state_t        state, state_nx;
    logic [SEL_WIDTH:0]   w_m1;
    logic [H_WIDTH-1:0]   h_last;
    logic [H_WIDTH-1:0]   row, tag_row;
    logic [SEL_WIDTH-1:0] col, tag_col;
    logic                 dims_ok, accept, last_rd, win_hit;

    assign w_m1      = tile_w - 1'b1;
    assign dims_ok   = tile_dims_ok(int'(tile_w), int'(tile_h), 2**SEL_WIDTH, 2**H_WIDTH - 1);
    assign accept    = state == IDLE && start && dims_ok;
    assign last_rd   = row == h_last && col == sel;
    assign win_hit   = chain_run && tag_row >= EDGE_ROW && tag_col >= EDGE_COL;
    assign pixel_out = mem_rd_data;

    tile_counter #(
        .SEL_WIDTH (SEL_WIDTH),
        .H_WIDTH   (H_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cnt (
        .clock   (clock),
        .rst_n   (rst_n),
        .load    (accept),
        .en      (mem_rd_en),
        .base    (base_addr),
        .col_last(sel),
        .row     (row),
        .col     (col),
        .addr    (mem_rd_addr)
    );

    // Sequence state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and control strobes; stall gates the read in the same cycle.
    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        busy      = state != IDLE;
        done      = state == DONE;
        case (state)
            IDLE:  state_nx = accept ? RUN : IDLE;
            RUN: begin
                mem_rd_en = !stall;
                state_nx  = (!stall && last_rd) ? DRAIN : RUN;
            end
            DRAIN: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Tile descriptor captured on an accepted start; sel stays put for the tile.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sel    <= '0;
            h_last <= '0;
        end else if (accept) begin
            sel    <= w_m1[SEL_WIDTH-1:0];
            h_last <= tile_h - 1'b1;
        end
    end

    // Rejected starts pulse err for one cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= state == IDLE && start && !dims_ok;
    end

    // Read-to-push pipeline: the tag travels with the data, and a push that
    // completes a window raises window_valid one cycle later.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            chain_run    <= 1'b0;
            tag_row      <= '0;
            tag_col      <= '0;
            window_valid <= 1'b0;
            win_row      <= '0;
            win_col      <= '0;
        end else begin
            chain_run    <= mem_rd_en;
            window_valid <= win_hit;
            if (mem_rd_en) begin
                tag_row <= row;
                tag_col <= col;
            end
            if (win_hit) begin
                win_row <= tag_row;
                win_col <= tag_col;
            end
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder: table-driven and randomized-stall checks of pixel_feeder against a raster model
module tb_pixel_feeder;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  tile_w = '0;
    logic [7:0]  tile_h = '0;
    logic [9:0]  base_addr = '0;
    logic        stall = 1'b0;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] pixel_out;
    logic        chain_run;
    logic [4:0]  sel;
    logic        window_valid;
    logic [7:0]  win_row;
    logic [4:0]  win_col;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    pixel_feeder dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .tile_w      (tile_w),
        .tile_h      (tile_h),
        .base_addr   (base_addr),
        .stall       (stall),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .pixel_out   (pixel_out),
        .chain_run   (chain_run),
        .sel         (sel),
        .window_valid(window_valid),
        .win_row     (win_row),
        .win_col     (win_col),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] pix(input int a);
        return 16'((a * 7 + 'h1234) & 'hFFFF);
    endfunction

    // SRAM model: one-cycle read latency, junk when not read.
    always @(posedge clock) mem_rd_data <= mem_rd_en ? pix(int'(mem_rd_addr)) : 16'($urandom);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(mem_rd_addr), 0);
        chk({tag, "_chain_run"}, int'(chain_run), 0);
        chk({tag, "_window_valid"}, int'(window_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_sel"}, int'(sel), 0);
        chk({tag, "_win_row"}, int'(win_row), 0);
        chk({tag, "_win_col"}, int'(win_col), 0);
    endtask

    // mode: 0 no stall, 1 stall cycles 6..8, 2 random stall
    typedef struct {
        int w;
        int h;
        int base;
        int mode;
        bit poke;
        bit exp_err;
        int exp_sel;
        int exp_wins;
        int exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        int total = v.w * v.h;
        int reads = 0, pushes = 0, wins = 0, stalls = 0, done_k = -1;
        int prev_push = -1, cur_push;
        bit last_rd = 1'b0, exp_wv, exp_rd;
        @(posedge clock);
        #1;
        tile_w = 6'(v.w);
        tile_h = 8'(v.h);
        base_addr = 10'(v.base);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; ; k++) begin
            stall = v.mode == 1 ? (k >= 6 && k <= 8) : v.mode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (v.poke && k == 4) begin
                tile_w = 6'd2;
                tile_h = 8'd9;
                start = 1'b1;
            end
            @(negedge clock);
            if (v.exp_err) begin
                chk("err_pulse", int'(err), int'(k == 1));
                chk("err_no_read", int'(mem_rd_en), 0);
                chk("err_busy", int'(busy), 0);
                if (k == 4) break;
            end else begin
                chk("busy", int'(busy), int'(done_k < 0));
                chk("err_quiet", int'(err), 0);
                if (k == 1) chk("sel", int'(sel), v.exp_sel);
                exp_rd = reads < total && !stall;
                if (reads < total && stall) stalls++;
                chk("rd_en", int'(mem_rd_en), int'(exp_rd));
                if (mem_rd_en) begin
                    chk("rd_addr", int'(mem_rd_addr), (v.base + reads) % 1024);
                    reads++;
                end
                chk("chain_run", int'(chain_run), int'(last_rd));
                exp_wv = prev_push >= 0 && prev_push / v.w >= 2 && prev_push % v.w >= 2;
                chk("window_valid", int'(window_valid), int'(exp_wv));
                if (window_valid && exp_wv) begin
                    chk("win_row", int'(win_row), prev_push / v.w);
                    chk("win_col", int'(win_col), prev_push % v.w);
                end
                if (window_valid) wins++;
                cur_push = -1;
                if (chain_run) begin
                    chk("pixel", int'(pixel_out), int'(pix((v.base + pushes) % 1024)));
                    cur_push = pushes;
                    pushes++;
                end
                chk("done", int'(done), int'(k == total + 2 + stalls));
                if (done && done_k < 0) done_k = k;
                last_rd = mem_rd_en;
                prev_push = cur_push;
                if (done_k >= 0 && k > done_k) break;
                if (k > 5 * total + 20) begin
                    chk("timeout_done", 0, 1);
                    break;
                end
            end
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!v.exp_err) begin
            chk("reads_total", reads, total);
            chk("pushes_total", pushes, total);
            chk("windows_total", wins, v.exp_wins);
            chk("done_cycle", done_k, v.exp_done + (v.mode == 2 ? stalls : 0));
            chk("sel_end", int'(sel), v.exp_sel);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        //                w   h   base   mode poke err sel wins done
        vecs.push_back('{ 4,  3, 'h010, 0,   0,   0,  3,  2,  14});
        vecs.push_back('{ 4,  3, 'h010, 1,   0,   0,  3,  2,  17});
        vecs.push_back('{ 2,  5, 'h000, 0,   0,   1,  0,  0,   0});
        vecs.push_back('{32,  3, 'h3F0, 0,   0,   0, 31, 30,  98});
        vecs.push_back('{ 5,  4, 'h100, 2,   0,   0,  4,  6,  22});
        vecs.push_back('{33,  4, 'h000, 0,   0,   1,  0,  0,   0});
        vecs.push_back('{ 3,  3, 'h3FE, 2,   0,   0,  2,  1,  11});
        vecs.push_back('{ 8,  2, 'h000, 0,   0,   1,  0,  0,   0});
        vecs.push_back('{ 6,  7, 'h2A0, 2,   0,   0,  5, 20,  44});
        vecs.push_back('{ 4,  3, 'h010, 0,   1,   0,  3,  2,  14});
        #12;
        check_zero("por");
        @(negedge clock);
        rst_n = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);
        // Reset in the middle of a running tile.
        @(posedge clock);
        #1;
        tile_w = 6'd6;
        tile_h = 8'd7;
        base_addr = 10'h155;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clock);
        rst_n = 1'b1;
        run_vec('{6, 7, 'h155, 2, 0, 0, 5, 20, 44});
        // A few extra random tiles.
        for (int i = 0; i < 4; i++) begin
            int w = $urandom_range(3, 32);
            int h = $urandom_range(3, 6);
            run_vec('{w, h, int'($urandom_range(0, 1023)), 2, 0, 0, w - 1, (h - 2) * (w - 2), w * h + 2});
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
